// File: rtl/board_state.sv
// Playfield owner for the brick game: brick/paddle occupancy map, brick clearing from ball
// contact, score/lives bookkeeping and the serve/miss/win sequencing that gates ball_movement.
module board_state #(
  parameter int unsigned BRICK_ROWS = 4,
  parameter int unsigned PADDLE_W   = 4,
  parameter int unsigned LIVES      = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic [3:0]   ball_row,
  input  logic [3:0]   ball_col,
  input  logic [1:0]   ball_dir,
  output logic [191:0] data,
  output logic         ball_rst_n,
  output logic [7:0]   score,
  output logic [2:0]   lives,
  output logic [2:0]   game_state
);

  localparam int unsigned COLS     = 16;
  localparam int unsigned CELLS    = 192;
  localparam int unsigned LAST_ROW = 11;

  localparam logic [CELLS-1:0] BRICKS_INIT = ~({CELLS{1'b1}} << (BRICK_ROWS * COLS));
  localparam logic [CELLS-1:0] PADDLE_ONES = ~({CELLS{1'b1}} << PADDLE_W);
  localparam logic [3:0]       PADDLE_MAX  = 4'(COLS - PADDLE_W);
  localparam logic [3:0]       PADDLE_HOME = 4'((COLS - PADDLE_W) / 2);
  localparam logic [2:0]       LIVES_INIT  = 3'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_MISS = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  function automatic logic [CELLS-1:0] paddle_mask(input logic [3:0] pos);
    return PADDLE_ONES << (LAST_ROW * COLS + 32'(pos));
  endfunction

  // One column per accepted edge; opposing edges cancel; clamped at both walls.
  function automatic logic [3:0] step_paddle(input logic [3:0] pos, input logic up, input logic dn);
    if (up && !dn && pos < PADDLE_MAX) return pos + 4'd1;
    if (dn && !up && pos != 4'd0)      return pos - 4'd1;
    return pos;
  endfunction

  state_t           state, state_n;
  logic [CELLS-1:0] bricks, bricks_n, data_n;
  logic [3:0]       paddle_pos, paddle_n, paddle_step;
  logic [7:0]       score_n;
  logic [2:0]       lives_n;
  logic             prev_left, prev_right;
  logic [1:0]       n_clr;
  logic [8:0]       score_sum;

  logic [4:0] dr, dc, vr, hc;
  logic       row_ok, v_ok, h_ok, d_ok, v_hit, h_hit, d_hit;
  logic [7:0] idx_v, idx_h, idx_d;

  // Neighbour cells in the ball's direction of travel, with 5-bit wrap as the invalid flag.
  always_comb begin
    dr     = ball_dir[1] ? 5'd1 : 5'h1f;
    dc     = ball_dir[0] ? 5'd1 : 5'h1f;
    vr     = {1'b0, ball_row} + dr;
    hc     = {1'b0, ball_col} + dc;
    row_ok = ball_row <= 4'(LAST_ROW);
    v_ok   = row_ok && !vr[4] && (vr <= 5'(LAST_ROW));
    h_ok   = row_ok && !hc[4];
    d_ok   = v_ok && h_ok;
    idx_v  = {vr[3:0], ball_col};
    idx_h  = {ball_row, hc[3:0]};
    idx_d  = {vr[3:0], hc[3:0]};
    // data always equals bricks | paddle, so it serves as the occupancy map.
    v_hit  = v_ok && data[idx_v];
    h_hit  = h_ok && data[idx_h];
    d_hit  = d_ok && data[idx_d];
  end

  assign paddle_step = step_paddle(paddle_pos, btn_left & ~prev_left, btn_right & ~prev_right);

  always_comb begin
    state_n  = state;
    bricks_n = bricks;
    paddle_n = paddle_pos;
    score_n  = score;
    lives_n  = lives;
    n_clr    = 2'd0;
    case (state)
      S_PLAY: begin
        paddle_n = paddle_step;
        if (ball_row == 4'(LAST_ROW)) begin
          state_n = S_MISS;
        end else if (bricks == '0) begin
          state_n = S_WIN;
        end else if (v_hit || h_hit) begin
          if (v_hit && bricks[idx_v]) begin
            bricks_n[idx_v] = 1'b0;
            n_clr           = n_clr + 2'd1;
          end
          if (h_hit && bricks[idx_h]) begin
            bricks_n[idx_h] = 1'b0;
            n_clr           = n_clr + 2'd1;
          end
        end else if (d_hit && bricks[idx_d]) begin
          bricks_n[idx_d] = 1'b0;
          n_clr           = 2'd1;
        end
      end
      S_MISS: begin
        lives_n = lives - 3'd1;
        state_n = (lives == 3'd1) ? S_OVER : S_IDLE;
      end
      S_WIN, S_OVER: begin
        if (start) begin
          state_n  = S_IDLE;
          bricks_n = BRICKS_INIT;
          paddle_n = PADDLE_HOME;
          lives_n  = LIVES_INIT;
          score_n  = 8'd0;
        end
      end
      default: begin
        paddle_n = paddle_step;
        state_n  = start ? S_PLAY : S_IDLE;
      end
    endcase
    score_sum = 9'(score) + 9'(n_clr);
    if (state == S_PLAY) score_n = score_sum[8] ? 8'hff : score_sum[7:0];
    data_n = bricks_n | paddle_mask(paddle_n);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      bricks     <= BRICKS_INIT;
      paddle_pos <= PADDLE_HOME;
      score      <= 8'd0;
      lives      <= LIVES_INIT;
      prev_left  <= 1'b0;
      prev_right <= 1'b0;
      data       <= BRICKS_INIT | paddle_mask(PADDLE_HOME);
    end else begin
      state      <= state_n;
      bricks     <= bricks_n;
      paddle_pos <= paddle_n;
      score      <= score_n;
      lives      <= lives_n;
      prev_left  <= btn_left;
      prev_right <= btn_right;
      data       <= data_n;
    end
  end

  assign ball_rst_n = (state == S_PLAY);
  assign game_state = 3'(state);

endmodule

// File: tb/tb_board_state.sv
// Directed self-checking bench for board_state: reset, paddle, brick clearing, miss/over, win/reload.
module tb_board_state;

  logic         clock, reset, start, btn_left, btn_right;
  logic [3:0]   ball_row, ball_col;
  logic [1:0]   ball_dir;
  logic [191:0] data;
  logic         ball_rst_n;
  logic [7:0]   score;
  logic [2:0]   lives, game_state;

  int checks = 0;
  int errors = 0;

  board_state dut (
    .clock(clock), .reset(reset), .start(start), .btn_left(btn_left), .btn_right(btn_right),
    .ball_row(ball_row), .ball_col(ball_col), .ball_dir(ball_dir),
    .data(data), .ball_rst_n(ball_rst_n), .score(score), .lives(lives), .game_state(game_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic park();
    ball_row = 4'd9; ball_col = 4'd9; ball_dir = 2'd0;
  endtask

  task automatic press_left();
    btn_left = 1'b1; tick(); btn_left = 1'b0; tick();
  endtask

  task automatic press_right();
    btn_right = 1'b1; tick(); btn_right = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; btn_left = 1'b0; btn_right = 1'b0; park();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (data[63:0] !== {64{1'b1}}) begin errors++; $display("FAIL reset_bricks: got %h expected all ones", data[63:0]); end
    checks++; if (data[175:64] !== '0) begin errors++; $display("FAIL reset_empty: got %h expected 0", data[175:64]); end
    checks++; if (data[191:176] !== 16'h03c0) begin errors++; $display("FAIL reset_paddle: got %h expected 03c0", data[191:176]); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
    checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives: got %0d expected 3", lives); end
    checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", game_state); end
    checks++; if (ball_rst_n !== 1'b0) begin errors++; $display("FAIL reset_ball_rst_n: got %b expected 0", ball_rst_n); end
    reset = 1'b1;
  endtask

  task automatic test_start_paddle();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", game_state); end
    checks++; if (ball_rst_n !== 1'b1) begin errors++; $display("FAIL start_ball_rst_n: got %b expected 1", ball_rst_n); end
    repeat (3) press_left();
    checks++; if (data[191:176] !== 16'h1e00) begin errors++; $display("FAIL paddle_left3: got %h expected 1e00", data[191:176]); end
    btn_left = 1'b1; repeat (3) tick(); btn_left = 1'b0; tick();
    checks++; if (data[191:176] !== 16'h3c00) begin errors++; $display("FAIL paddle_held: got %h expected 3c00", data[191:176]); end
    btn_left = 1'b1; btn_right = 1'b1; tick(); btn_left = 1'b0; btn_right = 1'b0; tick();
    checks++; if (data[191:176] !== 16'h3c00) begin errors++; $display("FAIL paddle_both: got %h expected 3c00", data[191:176]); end
    press_right();
    checks++; if (data[191:176] !== 16'h1e00) begin errors++; $display("FAIL paddle_right: got %h expected 1e00", data[191:176]); end
  endtask

  task automatic test_clear_single();
    ball_row = 4'd4; ball_col = 4'd5; ball_dir = 2'd0; tick(); park();
    checks++; if (data[53] !== 1'b0) begin errors++; $display("FAIL single_cleared: got %b expected 0", data[53]); end
    checks++; if (data[52] !== 1'b1) begin errors++; $display("FAIL single_diag_kept: got %b expected 1", data[52]); end
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL single_score: got %0d expected 1", score); end
  endtask

  task automatic test_clear_double();
    ball_row = 4'd3; ball_col = 4'd5; ball_dir = 2'd1; tick(); park();
    checks++; if (data[37] !== 1'b0 || data[54] !== 1'b0) begin errors++; $display("FAIL double_cleared: got %b%b expected 00", data[37], data[54]); end
    checks++; if (data[38] !== 1'b1) begin errors++; $display("FAIL double_diag_kept: got %b expected 1", data[38]); end
    checks++; if (score !== 8'd3) begin errors++; $display("FAIL double_score: got %0d expected 3", score); end
  endtask

  task automatic test_diag_and_edges();
    ball_row = 4'd4; ball_col = 4'd5; ball_dir = 2'd0; tick(); park();
    checks++; if (data[52] !== 1'b0) begin errors++; $display("FAIL diag_cleared: got %b expected 0", data[52]); end
    checks++; if (score !== 8'd4) begin errors++; $display("FAIL diag_score: got %0d expected 4", score); end
    ball_row = 4'd0; ball_col = 4'd0; ball_dir = 2'd0; tick(); park();
    checks++; if (score !== 8'd4 || data[0] !== 1'b1) begin errors++; $display("FAIL corner_invalid: got score %0d bit %b expected 4 1", score, data[0]); end
    ball_row = 4'd10; ball_col = 4'd10; ball_dir = 2'd3; tick(); park();
    checks++; if (score !== 8'd4 || data[191:176] !== 16'h1e00) begin errors++; $display("FAIL paddle_not_cleared: got score %0d paddle %h expected 4 1e00", score, data[191:176]); end
  endtask

  task automatic test_miss_over();
    logic [2:0] exp_lives, exp_state;
    ball_row = 4'd11; tick(); park();
    checks++; if (game_state !== 3'd2 || ball_rst_n !== 1'b0) begin errors++; $display("FAIL miss_state: got %0d/%b expected 2/0", game_state, ball_rst_n); end
    tick();
    checks++; if (game_state !== 3'd0 || lives !== 3'd2) begin errors++; $display("FAIL miss_lives: got state %0d lives %0d expected 0 2", game_state, lives); end
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; tick(); start = 1'b0;
      ball_row = 4'd11; tick(); park(); tick();
      exp_lives = (i == 0) ? 3'd1 : 3'd0;
      exp_state = (i == 0) ? 3'd0 : 3'd4;
      checks++; if (game_state !== exp_state || lives !== exp_lives) begin errors++; $display("FAIL miss_repeat%0d: got state %0d lives %0d expected %0d %0d", i, game_state, lives, exp_state, exp_lives); end
    end
    checks++; if (data[53] !== 1'b0 || score !== 8'd4) begin errors++; $display("FAIL over_kept: got bit %b score %0d expected 0 4", data[53], score); end
    press_left();
    checks++; if (data[191:176] !== 16'h1e00) begin errors++; $display("FAIL over_paddle_frozen: got %h expected 1e00", data[191:176]); end
  endtask

  task automatic test_win_reload();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (game_state !== 3'd0 || data[63:0] !== {64{1'b1}} || score !== 8'd0 || lives !== 3'd3 || data[191:176] !== 16'h03c0) begin
      errors++; $display("FAIL over_reload: got state %0d bricks %h score %0d lives %0d paddle %h", game_state, data[63:0], score, lives, data[191:176]); end
    start = 1'b1; tick(); start = 1'b0;
    for (int r = 3; r >= 0; r--) begin
      for (int c = 0; c < 16; c++) begin
        ball_row = 4'(r + 1); ball_col = 4'(c); ball_dir = 2'd0; tick();
      end
    end
    park();
    checks++; if (score !== 8'd64 || data[63:0] !== '0 || game_state !== 3'd1) begin errors++; $display("FAIL sweep: got score %0d bricks %h state %0d expected 64 0 1", score, data[63:0], game_state); end
    tick();
    checks++; if (game_state !== 3'd3 || ball_rst_n !== 1'b0) begin errors++; $display("FAIL win_state: got %0d/%b expected 3/0", game_state, ball_rst_n); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (game_state !== 3'd0 || data[63:0] !== {64{1'b1}} || score !== 8'd0) begin errors++; $display("FAIL win_reload: got state %0d bricks %h score %0d", game_state, data[63:0], score); end
    repeat (7) press_right();
    checks++; if (data[191:176] !== 16'h000f) begin errors++; $display("FAIL clamp_right: got %h expected 000f", data[191:176]); end
    repeat (14) press_left();
    checks++; if (data[191:176] !== 16'hf000) begin errors++; $display("FAIL clamp_left: got %h expected f000", data[191:176]); end
  endtask

  task automatic test_async_reset();
    start = 1'b1; tick(); start = 1'b0;
    ball_row = 4'd4; ball_col = 4'd5; ball_dir = 2'd0; tick(); park();
    checks++; if (score !== 8'd1 || game_state !== 3'd1) begin errors++; $display("FAIL pre_reset: got score %0d state %0d expected 1 1", score, game_state); end
    #2 reset = 1'b0;
    #1;
    checks++; if (game_state !== 3'd0 || ball_rst_n !== 1'b0 || score !== 8'd0 || data[53] !== 1'b1 || data[191:176] !== 16'h03c0) begin
      errors++; $display("FAIL async_reset: got state %0d rst %b score %0d bit %b paddle %h", game_state, ball_rst_n, score, data[53], data[191:176]); end
    tick(); reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start_paddle();
    test_clear_single();
    test_clear_double();
    test_diag_and_edges();
    test_miss_over();
    test_win_reload();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
